// File: rtl/vga_osd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_osd_pkg
// Purpose  : Shared geometry constants, pipeline types and the font ROM
//            lookup for the VGA on-screen-display overlay.
// Revision : 1.0  initial release
// ============================================================================
package vga_osd_pkg;

    localparam int OSD_COLS = 32;
    localparam int OSD_ROWS = 16;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 8;
    localparam int PIPE_LAT = 3;
    localparam int ATTR_BIT = 7;
    localparam int COLOR_W  = 6;
    localparam int CNT_W    = 11;
    localparam int CHAR_AW  = 9;
    localparam int FRAME_W  = 5;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

    // Glyph rows packed top row first; bit 7 of each row is the leftmost pixel.
    function automatic logic [7:0] font_row(input logic [6:0] code, input logic [2:0] row);
        logic [63:0] glyph;
        case (code)
            7'h30:   glyph = 64'h3C666E7666663C00;
            7'h31:   glyph = 64'h1838181818187E00;
            7'h41:   glyph = 64'h183C66667E666600;
            7'h42:   glyph = 64'h7C66667C66667C00;
            7'h43:   glyph = 64'h3C66606060663C00;
            7'h7F:   glyph = 64'hFFFFFFFFFFFFFFFF;
            default: glyph = 64'h0000000000000000;
        endcase
        return glyph[{~row, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_osd_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_osd_if
// Purpose  : Video stream, character-buffer write port and mixed output of
//            the OSD overlay, grouped for connection between source and core.
// Revision : 1.0  initial release
// ============================================================================
interface vga_osd_if;
    import vga_osd_pkg::*;

    logic                osd_en;
    logic                wr_en;
    logic [CHAR_AW-1:0]  wr_addr;
    logic [7:0]          wr_data;
    logic [COLOR_W-1:0]  in_r, in_g, in_b;
    logic                in_hs, in_vs, in_blank;
    logic [CNT_W-1:0]    in_hcount, in_vcount;
    logic [COLOR_W-1:0]  out_r, out_g, out_b;
    logic                out_hs, out_vs, out_blank;

    modport master (
        output osd_en, wr_en, wr_addr, wr_data,
        output in_r, in_g, in_b, in_hs, in_vs, in_blank, in_hcount, in_vcount,
        input  out_r, out_g, out_b, out_hs, out_vs, out_blank
    );

    modport slave (
        input  osd_en, wr_en, wr_addr, wr_data,
        input  in_r, in_g, in_b, in_hs, in_vs, in_blank, in_hcount, in_vcount,
        output out_r, out_g, out_b, out_hs, out_vs, out_blank
    );

endinterface
`default_nettype wire

// File: rtl/vga_osd_charbuf.sv
`default_nettype none
// ============================================================================
// Module   : osd_charbuf
// Purpose  : 512x8 character buffer, one write port and one registered
//            read port; a same-cycle read of the written cell returns old data.
// Revision : 1.0  initial release
// ============================================================================
module osd_charbuf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/vga_osd.sv
`default_nettype none
// ============================================================================
// Module   : vga_osd
// Purpose  : 32x16 character overlay mixed into a VGA stream, 3-clock
//            pipeline. Define VGA_OSD_DIM_EN to halve the window background.
// Revision : 1.0  initial release
// ============================================================================
module vga_osd
    import vga_osd_pkg::*;
#(
    parameter int OSD_X = 192,
    parameter int OSD_Y = 176
) (
    input  logic      clk,
    input  logic      reset,
    vga_osd_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_x0 = CNT_W'(OSD_X);
    localparam logic [CNT_W-1:0] c_y0 = CNT_W'(OSD_Y);
    localparam logic [CNT_W-1:0] c_w  = CNT_W'(OSD_COLS * GLYPH_W);
    localparam logic [CNT_W-1:0] c_h  = CNT_W'(OSD_ROWS * GLYPH_H);

    logic [CNT_W-1:0]   w_hrel, w_vrel;
    logic               w_in_win, w_vs_fall, w_on;
    logic [CHAR_AW-1:0] w_rd_addr;
    logic [7:0]         w_cell;
    rgb_t               w_bg, w_mix;

    logic               r_vs_prev, r_osd_en;
    logic [FRAME_W-1:0] r_frame;
    logic               r1_valid, r1_act;
    logic [2:0]         r1_gx, r1_gy;
    rgb_t               r1_col;
    sync_t              r1_sync;
    logic               r2_valid, r2_act, r2_blink;
    logic [2:0]         r2_gx;
    logic [7:0]         r2_font;
    rgb_t               r2_col;
    sync_t              r2_sync;
    rgb_t               r_out_col;
    sync_t              r_out_sync;

    // Explicit lower bounds stop small counters from wrapping into the window.
    assign w_hrel    = bus.in_hcount - c_x0;
    assign w_vrel    = bus.in_vcount - c_y0;
    assign w_in_win  = (bus.in_hcount >= c_x0) && (w_hrel < c_w) &&
                       (bus.in_vcount >= c_y0) && (w_vrel < c_h);
    assign w_rd_addr = {w_vrel[6:3], w_hrel[7:3]};
    assign w_vs_fall = r_vs_prev & ~bus.in_vs;

    osd_charbuf #(
        .DEPTH (OSD_COLS * OSD_ROWS),
        .AW    (CHAR_AW),
        .DW    (8)
    ) u_charbuf (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_cell)
    );

    // osd_en is sampled only at frame start so a frame is never half overlaid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev <= 1'b1;
            r_frame   <= '0;
            r_osd_en  <= 1'b0;
        end else begin
            r_vs_prev <= bus.in_vs;
            if (w_vs_fall) begin
                r_frame  <= r_frame + FRAME_W'(1);
                r_osd_en <= bus.osd_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_act   <= 1'b0;
            r1_gx    <= '0;
            r1_gy    <= '0;
            r1_col   <= '0;
            r1_sync  <= SYNC_IDLE;
            r2_valid <= 1'b0;
            r2_act   <= 1'b0;
            r2_blink <= 1'b0;
            r2_gx    <= '0;
            r2_font  <= '0;
            r2_col   <= '0;
            r2_sync  <= SYNC_IDLE;
        end else begin
            r1_valid <= 1'b1;
            r1_act   <= w_in_win & r_osd_en;
            r1_gx    <= w_hrel[2:0];
            r1_gy    <= w_vrel[2:0];
            r1_col   <= rgb_t'({bus.in_r, bus.in_g, bus.in_b});
            r1_sync  <= sync_t'({bus.in_hs, bus.in_vs, bus.in_blank});
            r2_valid <= r1_valid;
            r2_act   <= r1_act;
            r2_blink <= w_cell[ATTR_BIT];
            r2_gx    <= r1_gx;
            r2_font  <= font_row(w_cell[6:0], r1_gy);
            r2_col   <= r1_col;
            r2_sync  <= r1_sync;
        end
    end

    assign w_on = r2_font[~r2_gx] & ~(r2_blink & r_frame[FRAME_W-1]);

`ifdef VGA_OSD_DIM_EN
    assign w_bg = '{r: r2_col.r >> 1, g: r2_col.g >> 1, b: r2_col.b >> 1};
`else
    assign w_bg = r2_col;
`endif

    always_comb begin
        w_mix = r2_col;
        if (r2_sync.blank) begin
            w_mix = '0;
        end else if (!r2_act) begin
            w_mix = r2_col;
        end else if (w_on) begin
            w_mix = '1;
        end else begin
            w_mix = w_bg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !r2_valid) begin
            r_out_col  <= '0;
            r_out_sync <= SYNC_IDLE;
        end else begin
            r_out_col  <= w_mix;
            r_out_sync <= r2_sync;
        end
    end

    assign bus.out_r     = r_out_col.r;
    assign bus.out_g     = r_out_col.g;
    assign bus.out_b     = r_out_col.b;
    assign bus.out_hs    = r_out_sync.hs;
    assign bus.out_vs    = r_out_sync.vs;
    assign bus.out_blank = r_out_sync.blank;

endmodule
`default_nettype wire

// File: tb/tb_vga_osd.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_osd
// Purpose  : Directed, table-driven self-checking bench for vga_osd.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_osd;

    localparam logic [17:0] COL  = {6'h2A, 6'h2A, 6'h2A};
    localparam logic [17:0] MIX3 = {6'h11, 6'h22, 6'h33};
    localparam logic [17:0] ON   = 18'h3FFFF;
`ifdef VGA_OSD_DIM_EN
    localparam logic [17:0] BG   = {6'h15, 6'h15, 6'h15};
`else
    localparam logic [17:0] BG   = COL;
`endif
    localparam logic [2:0] S_ACT  = 3'b110;
    localparam logic [2:0] S_IDLE = 3'b111;

    typedef struct {
        string       name;
        logic [10:0] h;
        logic [10:0] v;
        logic [17:0] col;
        logic [2:0]  sync;
        logic [17:0] exp_col;
        logic [2:0]  exp_sync;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] tb_frame = 5'd0;
    vec_t       vecs [16];

    always #20 clk = ~clk;

    vga_osd_if bus ();

    vga_osd #(.OSD_X(192), .OSD_Y(176)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input string n, input int h, input int v, input logic [17:0] c,
                                input logic [2:0] s, input logic [17:0] ec, input logic [2:0] es);
        vec_t t;
        t.name = n; t.h = 11'(h); t.v = 11'(v); t.col = c; t.sync = s;
        t.exp_col = ec; t.exp_sync = es;
        return t;
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [17:0] ec, input logic [2:0] es);
        check({name, "_col"}, {bus.out_r, bus.out_g, bus.out_b}, ec);
        check({name, "_sync"}, {15'd0, bus.out_hs, bus.out_vs, bus.out_blank}, {15'd0, es});
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic [17:0] c,
                         input logic [2:0] s);
        bus.in_hcount = h;
        bus.in_vcount = v;
        {bus.in_r, bus.in_g, bus.in_b} = c;
        {bus.in_hs, bus.in_vs, bus.in_blank} = s;
    endtask

    task automatic apply(input logic [10:0] h, input logic [10:0] v, input logic [17:0] c,
                         input logic [2:0] s);
        drive(h, v, c, s);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        drive(11'd0, 11'd0, 18'd0, 3'b111);
        repeat (2) tick();
        bus.in_vs = 1'b0;
        repeat (2) tick();
        bus.in_vs = 1'b1;
        repeat (2) tick();
        tb_frame = tb_frame + 5'd1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 9'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk("a_r0_x0",      192, 176, COL,  S_ACT,  BG,    S_ACT);
        vecs[1]  = mk("a_r0_x3",      195, 176, COL,  S_ACT,  ON,    S_ACT);
        vecs[2]  = mk("left_out",     191, 176, MIX3, S_ACT,  MIX3,  S_ACT);
        vecs[3]  = mk("top_out",      192, 175, COL,  S_ACT,  COL,   S_ACT);
        vecs[4]  = mk("right_in",     447, 176, COL,  S_ACT,  BG,    S_ACT);
        vecs[5]  = mk("right_out",    448, 176, COL,  S_ACT,  COL,   S_ACT);
        vecs[6]  = mk("bottom_in",    192, 303, COL,  S_ACT,  BG,    S_ACT);
        vecs[7]  = mk("bottom_out",   192, 304, COL,  S_ACT,  COL,   S_ACT);
        vecs[8]  = mk("b_r0_x0",      200, 176, COL,  S_ACT,  BG,    S_ACT);
        vecs[9]  = mk("b_r0_x1",      201, 176, COL,  S_ACT,  ON,    S_ACT);
        vecs[10] = mk("a_r3_x1",      193, 179, COL,  S_ACT,  ON,    S_ACT);
        vecs[11] = mk("a_r3_x0",      192, 179, COL,  S_ACT,  BG,    S_ACT);
        vecs[12] = mk("blank_glyph",  195, 176, COL,  S_IDLE, 18'd0, S_IDLE);
        vecs[13] = mk("origin_nowrap",  0,   0, COL,  3'b010, COL,   3'b010);
        vecs[14] = mk("cell32_b",     193, 184, COL,  S_ACT,  ON,    S_ACT);
        vecs[15] = mk("a_r7",         195, 183, MIX3, S_ACT,
`ifdef VGA_OSD_DIM_EN
                      {6'h08, 6'h11, 6'h19},
`else
                      MIX3,
`endif
                      S_ACT);

        reset = 1'b1;
        bus.osd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        drive(11'd0, 11'd0, COL, S_ACT);
        repeat (3) tick();
        check_out("reset", 18'd0, S_IDLE);
        reset = 1'b0;
        repeat (2) tick();
        check_out("reset_rel_2clk", 18'd0, S_IDLE);
        tick();
        check_out("reset_rel_3clk", COL, S_ACT);

        for (int i = 0; i < 512; i++) wr(i, 8'h20);
        wr(0, 8'h41);
        wr(1, 8'h42);
        wr(5, 8'hC1);
        wr(32, 8'h42);

        // Enable raised mid-frame stays invisible until the next frame start.
        apply(11'd195, 11'd176, COL, S_ACT);
        check_out("en_off", COL, S_ACT);
        bus.osd_en = 1'b1;
        apply(11'd100, 11'd300, COL, S_ACT);
        apply(11'd195, 11'd176, COL, S_ACT);
        check_out("en_pending", COL, S_ACT);
        frame_pulse();
        apply(11'd195, 11'd176, COL, S_ACT);
        check_out("en_active", ON, S_ACT);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].h, vecs[i].v, vecs[i].col, vecs[i].sync);
            check_out(vecs[i].name, vecs[i].exp_col, vecs[i].exp_sync);
        end

        // Blink cell: visible while frame counter bit 4 is clear, across a wrap.
        for (int i = 0; i < 33; i++) begin
            apply(11'd235, 11'd176, COL, S_ACT);
            check("blink", {bus.out_r, bus.out_g, bus.out_b}, tb_frame[4] ? BG : ON);
            if (i < 32) frame_pulse();
        end

        // Write to cell 0 in the same cycle its pixel is presented.
        drive(11'd195, 11'd176, COL, S_ACT);
        bus.wr_en = 1'b1;
        bus.wr_addr = 9'd0;
        bus.wr_data = 8'h20;
        tick();
        bus.wr_en = 1'b0;
        drive(11'd195, 11'd177, COL, S_ACT);
        tick();
        drive(11'd100, 11'd300, COL, S_ACT);
        tick();
        check("wr_same_cycle_old", {bus.out_r, bus.out_g, bus.out_b}, ON);
        tick();
        check("wr_next_row_new", {bus.out_r, bus.out_g, bus.out_b}, BG);

        // Mid-frame reset.
        drive(11'd195, 11'd176, MIX3, 3'b010);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check_out("midframe_reset", 18'd0, S_IDLE);
        reset = 1'b0;
        tb_frame = 5'd0;
        repeat (2) tick();
        check_out("midframe_rel_2clk", 18'd0, S_IDLE);
        tick();
        check_out("midframe_rel_3clk", MIX3, 3'b010);
        frame_pulse();
        apply(11'd201, 11'd176, COL, S_ACT);
        check_out("buf_kept", ON, S_ACT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
